// File: rtl/mccpu_ctrl_if.sv
// Shared memory port between the multi-cycle control FSM (master) and the memory side (slave).
interface mccpu_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ack;
    logic IorD;

    modport master (output mem_req, output mem_we, output IorD, input mem_ack);
    modport slave  (input mem_req, input mem_we, input IorD, output mem_ack);
endinterface

// File: rtl/mccpu_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB over one req/ack memory port,
// drives the datapath strobes and traps on illegal opcodes or memory timeouts.
module mccpu_ctrl #(
    parameter int ALUOP_W = 4,
    parameter int MEM_TO  = 16,
    parameter int TO_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    mccpu_ctrl_if.master       mem,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic [1:0]         NPCOp,
    output logic               RegWrite,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               EXTOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               trap,
    output logic [2:0]         state
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_TRAP = 3'd7;

    localparam logic [ALUOP_W-1:0] ALU_NOP  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(11);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TO);

    typedef enum logic [3:0] {
        C_ILL, C_R, C_IMM, C_LW, C_SW, C_BR, C_J, C_JAL, C_JR, C_JALR, C_LUI
    } iclass_t;

    logic [2:0]         state_q, state_d;
    logic [TO_W-1:0]    to_cnt;
    iclass_t            cls;
    logic [ALUOP_W-1:0] dec_aluop;
    logic               dec_srca;
    logic [1:0]         dec_srcb;
    logic               dec_ext;
    logic               dec_bne;
    logic               req_state;
    logic               waiting;
    logic               to_hit;
    logic               req, we, iord;

    // Instruction decode: class plus the EX-stage ALU controls
    always_comb begin
        cls       = C_ILL;
        dec_aluop = ALU_NOP;
        dec_srca  = 1'b0;
        dec_srcb  = 2'b00;
        dec_ext   = 1'b0;
        dec_bne   = 1'b0;
        case (Op)
            6'h00: begin
                cls = C_R;
                case (Funct)
                    6'h20, 6'h21: dec_aluop = ALU_ADD;
                    6'h22, 6'h23: dec_aluop = ALU_SUB;
                    6'h24:        dec_aluop = ALU_AND;
                    6'h25:        dec_aluop = ALU_OR;
                    6'h26:        dec_aluop = ALU_XOR;
                    6'h27:        dec_aluop = ALU_NOR;
                    6'h2A:        dec_aluop = ALU_SLT;
                    6'h2B:        dec_aluop = ALU_SLTU;
                    6'h00: begin dec_aluop = ALU_SLL; dec_srca = 1'b1; dec_srcb = 2'b10; end
                    6'h02: begin dec_aluop = ALU_SRL; dec_srca = 1'b1; dec_srcb = 2'b10; end
                    6'h03: begin dec_aluop = ALU_SRA; dec_srca = 1'b1; dec_srcb = 2'b10; end
                    6'h04: begin dec_aluop = ALU_SLL; dec_srca = 1'b1; dec_srcb = 2'b11; end
                    6'h06: begin dec_aluop = ALU_SRL; dec_srca = 1'b1; dec_srcb = 2'b11; end
                    6'h07: begin dec_aluop = ALU_SRA; dec_srca = 1'b1; dec_srcb = 2'b11; end
                    6'h08:        cls = C_JR;
                    6'h09:        cls = C_JALR;
                    default:      cls = C_ILL;
                endcase
            end
            6'h08, 6'h09: begin cls = C_IMM; dec_aluop = ALU_ADD;  dec_srcb = 2'b01; dec_ext = 1'b1; end
            6'h0A:        begin cls = C_IMM; dec_aluop = ALU_SLT;  dec_srcb = 2'b01; dec_ext = 1'b1; end
            6'h0B:        begin cls = C_IMM; dec_aluop = ALU_SLTU; dec_srcb = 2'b01; dec_ext = 1'b1; end
            6'h0C:        begin cls = C_IMM; dec_aluop = ALU_AND;  dec_srcb = 2'b01; end
            6'h0D:        begin cls = C_IMM; dec_aluop = ALU_OR;   dec_srcb = 2'b01; end
            6'h0E:        begin cls = C_IMM; dec_aluop = ALU_XOR;  dec_srcb = 2'b01; end
            6'h0F:        cls = C_LUI;
            6'h23:        begin cls = C_LW;  dec_aluop = ALU_ADD;  dec_srcb = 2'b01; dec_ext = 1'b1; end
            6'h2B:        begin cls = C_SW;  dec_aluop = ALU_ADD;  dec_srcb = 2'b01; dec_ext = 1'b1; end
            6'h04:        begin cls = C_BR;  dec_aluop = ALU_SUB;  dec_ext = 1'b1; end
            6'h05:        begin cls = C_BR;  dec_aluop = ALU_SUB;  dec_ext = 1'b1; dec_bne = 1'b1; end
            6'h02:        cls = C_J;
            6'h03:        cls = C_JAL;
            default:      cls = C_ILL;
        endcase
    end

    // An ack arriving on the cycle the counter would reach the limit still completes the access
    assign req_state = (state_q == S_IF) || (state_q == S_MEM);
    assign waiting   = req_state && !mem.mem_ack;
    assign to_hit    = (MEM_TO != 0) && ((to_cnt + 1'b1) == TO_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            to_cnt  <= '0;
        end else begin
            state_q <= state_d;
            to_cnt  <= waiting ? to_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: begin
                if (mem.mem_ack)  state_d = S_ID;
                else if (to_hit)  state_d = S_TRAP;
            end
            S_ID: begin
                case (cls)
                    C_ILL:                              state_d = S_TRAP;
                    C_J, C_JAL, C_JR, C_JALR, C_LUI:    state_d = S_IF;
                    default:                            state_d = S_EX;
                endcase
            end
            S_EX: begin
                case (cls)
                    C_BR:       state_d = S_IF;
                    C_LW, C_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem.mem_ack)  state_d = (cls == C_SW) ? S_IF : S_WB;
                else if (to_hit)  state_d = S_TRAP;
            end
            S_WB:    state_d = S_IF;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IF;
        endcase
    end

    // Every strobe is forced low while rst is high so no write can slip out in the reset cycle
    always_comb begin
        req      = 1'b0;
        we       = 1'b0;
        iord     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        NPCOp    = 2'b00;
        RegWrite = 1'b0;
        GPRSel   = 2'b00;
        WDSel    = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        EXTOp    = 1'b0;
        ALUOp    = ALU_NOP;
        if (!rst) begin
            if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
                ALUOp   = dec_aluop;
                ALUSrcA = dec_srca;
                ALUSrcB = dec_srcb;
                EXTOp   = dec_ext;
            end
            case (state_q)
                S_IF: begin
                    req = 1'b1;
                    if (mem.mem_ack) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                    end
                end
                S_ID: begin
                    case (cls)
                        C_J:   begin PCWrite = 1'b1; NPCOp = 2'b10; end
                        C_JAL: begin
                            PCWrite = 1'b1; NPCOp = 2'b10;
                            RegWrite = 1'b1; GPRSel = 2'b10; WDSel = 2'b10;
                        end
                        C_JR:  begin PCWrite = 1'b1; NPCOp = 2'b11; end
                        C_JALR: begin
                            PCWrite = 1'b1; NPCOp = 2'b11;
                            RegWrite = 1'b1; GPRSel = 2'b00; WDSel = 2'b10;
                        end
                        C_LUI: begin RegWrite = 1'b1; GPRSel = 2'b01; WDSel = 2'b11; end
                        default: ;
                    endcase
                end
                S_EX: begin
                    if (cls == C_BR) begin
                        NPCOp   = 2'b01;
                        PCWrite = dec_bne ? !Zero : Zero;
                    end
                end
                S_MEM: begin
                    req  = 1'b1;
                    iord = 1'b1;
                    we   = (cls == C_SW);
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    GPRSel   = (cls == C_R) ? 2'b00 : 2'b01;
                    WDSel    = (cls == C_LW) ? 2'b01 : 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_req = req;
    assign mem.mem_we  = we;
    assign mem.IorD    = iord;
    assign trap        = (state_q == S_TRAP);
    assign state       = state_q;

endmodule
